// File: rtl/word_pack32_b.sv
// rtl/word_pack32_b.sv - byte-serial word storage reader packing little-endian 32-bit stream beats
module word_pack32_b #(
    parameter int WORD_MAX_LEN   = 10,
    parameter int RANGES_MAX     = 2,
    parameter int RANGE_INFO_MSB = (WORD_MAX_LEN > 1) ? $clog2(WORD_MAX_LEN) : 1
) (
    input  logic                                       CLK,
    input  logic                                       RST_N,
    input  logic [7:0]                                 din,
    output logic [((WORD_MAX_LEN > 1) ? $clog2(WORD_MAX_LEN) : 1)-1:0] rd_addr,
    input  logic [$clog2(WORD_MAX_LEN+1)-1:0]          word_len,
    input  logic [15:0]                                word_id,
    input  logic [RANGES_MAX*(RANGE_INFO_MSB+1)-1:0]   range_info,
    input  logic                                       word_list_end,
    input  logic                                       empty,
    output logic                                       set_empty,
    output logic [31:0]                                dout,
    output logic [2:0]                                 dout_bytes,
    output logic                                       dout_first,
    output logic                                       dout_last,
    output logic [15:0]                                out_word_id,
    output logic [$clog2(WORD_MAX_LEN+1)-1:0]          out_word_len,
    output logic [RANGES_MAX*(RANGE_INFO_MSB+1)-1:0]   out_range_info,
    output logic                                       out_list_end,
    output logic                                       valid,
    input  logic                                       ready
);

    // Address width covers 0..WORD_MAX_LEN-1, length width covers 0..WORD_MAX_LEN.
    // WORD_MAX_LEN is expected to be at least 4 so a full beat count fits the length width.
    localparam int ADDR_W = (WORD_MAX_LEN > 1) ? $clog2(WORD_MAX_LEN) : 1;
    localparam int LEN_W  = $clog2(WORD_MAX_LEN + 1);

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        FETCH      = 3'd1,
        OUT        = 3'd2,
        RELEASE    = 3'd3,
        WAIT_EMPTY = 3'd4
    } state_t;

    state_t             state;
    logic [LEN_W-1:0]   byte_ptr;
    logic               first_flag;
    // FETCH step counter: step c issues address byte_ptr+c (c < n) and captures lane c-1 (c >= 1)
    logic [2:0]         cnt;

    logic [LEN_W-1:0]   rem;
    logic [2:0]         n_bytes;
    logic [1:0]         lane;
    logic               beat_is_last;

    // Bytes remaining in the word and the size of the beat currently being fetched
    always_comb begin
        rem          = out_word_len - byte_ptr;
        n_bytes      = (rem >= LEN_W'(4)) ? 3'd4 : rem[2:0];
        lane         = 2'(cnt - 3'd1);
        beat_is_last = ((byte_ptr + LEN_W'(n_bytes)) == out_word_len);
    end

    // Main controller: sideband latch, byte fetch/pack, stream handshake and storage release
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state          <= IDLE;
            byte_ptr       <= '0;
            first_flag     <= 1'b0;
            cnt            <= '0;
            rd_addr        <= '0;
            set_empty      <= 1'b0;
            dout           <= '0;
            dout_bytes     <= '0;
            dout_first     <= 1'b0;
            dout_last      <= 1'b0;
            out_word_id    <= '0;
            out_word_len   <= '0;
            out_range_info <= '0;
            out_list_end   <= 1'b0;
            valid          <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (!empty) begin
                        out_word_len   <= word_len;
                        out_word_id    <= word_id;
                        out_range_info <= range_info;
                        out_list_end   <= word_list_end;
                        byte_ptr       <= '0;
                        cnt            <= '0;
                        dout           <= '0;
                        if (word_list_end || (word_len == '0)) begin
                            // Marker or empty word: single zero-byte beat, storage is never read
                            first_flag <= 1'b1;
                            dout_bytes <= 3'd0;
                            dout_first <= 1'b1;
                            dout_last  <= 1'b1;
                            valid      <= 1'b1;
                            state      <= OUT;
                        end else begin
                            first_flag <= 1'b1;
                            rd_addr    <= '0;
                            state      <= FETCH;
                        end
                    end
                end

                FETCH: begin
                    // din reflects the address issued on the previous step
                    if (cnt != 3'd0) begin
                        dout[{lane, 3'b000} +: 8] <= din;
                    end
                    if (cnt == n_bytes) begin
                        dout_bytes <= n_bytes;
                        dout_last  <= beat_is_last;
                        dout_first <= first_flag;
                        valid      <= 1'b1;
                        state      <= OUT;
                    end else begin
                        if ((cnt + 3'd1) < n_bytes) begin
                            rd_addr <= ADDR_W'(byte_ptr + LEN_W'(cnt) + LEN_W'(1));
                        end
                        cnt <= cnt + 3'd1;
                    end
                end

                OUT: begin
                    // Everything is held until the consumer takes the beat
                    if (ready) begin
                        valid      <= 1'b0;
                        first_flag <= 1'b0;
                        byte_ptr   <= byte_ptr + LEN_W'(dout_bytes);
                        if (dout_last) begin
                            set_empty <= 1'b1;
                            state     <= RELEASE;
                        end else begin
                            // Next beat starts at the byte after the ones just sent; lanes refilled from zero
                            rd_addr <= ADDR_W'(byte_ptr + LEN_W'(dout_bytes));
                            cnt     <= '0;
                            dout    <= '0;
                            state   <= FETCH;
                        end
                    end
                end

                RELEASE: begin
                    set_empty <= 1'b0;
                    state     <= WAIT_EMPTY;
                end

                WAIT_EMPTY: begin
                    // empty has not caught up with the release yet, so skip one look at it
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
